// File: rtl/prescaled_counter.sv
// Purpose : prescaler dividing clk by TICK_DIV, driving a wrap-around tick counter
//           with ms_tick / wrap pulses and a flip level that toggles on each wrap.
// Latency : all outputs registered; counter, ms_tick and wrap change on the tick edge itself.
// Backpr. : none; enable=0 freezes the prescaler phase, load/clear act on any edge.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset (highest priority)
//   enable   - prescaler advances only while high
//   clear    - synchronous clear of prescaler, counter, pulses and flip
//   load     - load counter from load_val (clamped to MAX_COUNT), suppresses the step
//   load_val - value to load
//   up_dn    - direction, 1 = up, 0 = down (only with PRESCALED_COUNTER_UPDOWN_EN)
//   counter  - tick count, 0..MAX_COUNT
//   ms_tick  - one-cycle pulse per prescaler period
//   wrap     - one-cycle pulse when the counter wraps
//   flip     - level toggling on every wrap
//
// Build option: define PRESCALED_COUNTER_UPDOWN_EN for bidirectional counting;
// without it the up_dn port is absent and the counter counts up only.
module prescaled_counter #(
  parameter int WIDTH     = 4,
  parameter int TICK_DIV  = 100000,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PRESCALED_COUNTER_UPDOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] counter,
  output logic             ms_tick,
  output logic             wrap,
  output logic             flip
);

  // TICK_DIV=1 would give a zero-width prescaler; keep at least one bit.
  localparam int PW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);

  logic [PW-1:0]    pre_cnt;
  logic             tick_edge;
  logic             dir_up;
  logic             at_end;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

`ifdef PRESCALED_COUNTER_UPDOWN_EN
  assign dir_up = up_dn;
`else
  assign dir_up = 1'b1;
`endif

  assign tick_edge = enable && (pre_cnt == PRE_LAST);

  // Next counter value on a tick; at_end marks the wrapping step.
  always_comb begin
    at_end   = 1'b0;
    step_val = counter;
    if (dir_up) begin
      at_end   = (counter >= MAX_C);
      step_val = at_end ? '0 : counter + WIDTH'(1);
    end else begin
      at_end   = (counter == '0);
      step_val = at_end ? MAX_C : counter - WIDTH'(1);
    end
  end

  // Loads beyond the terminal count saturate so the counter stays in range.
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
      counter <= '0;
      ms_tick <= 1'b0;
      wrap    <= 1'b0;
      flip    <= 1'b0;
    end else begin
      // Prescaler runs independently of load: a load never disturbs the phase.
      if (tick_edge) begin
        pre_cnt <= '0;
      end else if (enable) begin
        pre_cnt <= pre_cnt + PW'(1);
      end
      ms_tick <= tick_edge;

      if (load) begin
        counter <= load_clamped;
        wrap    <= 1'b0;
      end else if (tick_edge) begin
        counter <= step_val;
        wrap    <= at_end;
        flip    <= flip ^ at_end;
      end else begin
        wrap    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// Purpose : self-checking bench for prescaled_counter (WIDTH=4, TICK_DIV=5, MAX_COUNT=9).
// Latency : reference model updated on each rising edge, outputs compared on the falling edge.
// Backpr. : n/a; directed scenarios with literal expectations, then randomized traffic.
module tb_prescaled_counter;

  localparam int WIDTH     = 4;
  localparam int TICK_DIV  = 5;
  localparam int MAX_COUNT = 9;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
  logic             up_dn;
`endif
  logic [WIDTH-1:0] counter;
  logic             ms_tick;
  logic             wrap;
  logic             flip;

  int checks = 0;
  int errors = 0;

  prescaled_counter #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
`ifdef PRESCALED_COUNTER_UPDOWN_EN
    .up_dn   (up_dn),
`endif
    .counter (counter),
    .ms_tick (ms_tick),
    .wrap    (wrap),
    .flip    (flip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // m_en_edges counts enabled edges since the current period started.
  int m_en_edges = 0;
  int m_cnt      = 0;
  int m_ms       = 0;
  int m_wrap     = 0;
  int m_flip     = 0;
  bit m_valid    = 1'b0;

  always @(posedge clk) begin
    bit up;
    bit ticked;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
    up = up_dn;
`else
    up = 1'b1;
`endif
    ticked = 1'b0;
    if (reset || clear) begin
      m_en_edges = 0;
      m_cnt      = 0;
      m_ms       = 0;
      m_wrap     = 0;
      m_flip     = 0;
      if (reset) m_valid = 1'b1;
    end else begin
      m_wrap = 0;
      if (enable) begin
        m_en_edges = m_en_edges + 1;
        if (m_en_edges == TICK_DIV) begin
          ticked     = 1'b1;
          m_en_edges = 0;
        end
      end
      m_ms = ticked ? 1 : 0;
      if (load) begin
        m_cnt = (int'(load_val) < MAX_COUNT) ? int'(load_val) : MAX_COUNT;
      end else if (ticked) begin
        if (up) begin
          m_wrap = (m_cnt == MAX_COUNT) ? 1 : 0;
          m_cnt  = (m_cnt + 1) % (MAX_COUNT + 1);
        end else begin
          m_wrap = (m_cnt == 0) ? 1 : 0;
          m_cnt  = (m_cnt + MAX_COUNT) % (MAX_COUNT + 1);
        end
        if (m_wrap == 1) m_flip = 1 - m_flip;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_counter", int'(counter), m_cnt);
      chk("model_ms_tick", int'(ms_tick), m_ms);
      chk("model_wrap",    int'(wrap),    m_wrap);
      chk("model_flip",    int'(flip),    m_flip);
      chk("counter_in_range", (int'(counter) <= MAX_COUNT) ? 1 : 0, 1);
    end
  end

  // Advance n rising edges, landing on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
`ifdef PRESCALED_COUNTER_UPDOWN_EN
    up_dn    = 1'b1;
`endif
    cyc(3);
    chk("rst_counter", int'(counter), 0);
    chk("rst_ms_tick", int'(ms_tick), 0);
    chk("rst_wrap",    int'(wrap),    0);
    chk("rst_flip",    int'(flip),    0);

    // First ticks at the 5th, 10th and 15th enabled edges after release.
    reset  = 1'b0;
    enable = 1'b1;
    cyc(4);
    chk("pre_first_tick_ms", int'(ms_tick), 0);
    cyc(1);
    chk("tick1_ms", int'(ms_tick), 1);
    chk("tick1_cnt", int'(counter), 1);
    cyc(5);
    chk("tick2_cnt", int'(counter), 2);
    cyc(5);
    chk("tick3_cnt", int'(counter), 3);
    chk("tick3_wrap", int'(wrap), 0);

    // Tick 10 wraps 9 -> 0.
    cyc(35);
    chk("tick10_cnt",  int'(counter), 0);
    chk("tick10_wrap", int'(wrap),    1);
    chk("tick10_flip", int'(flip),    1);
    cyc(1);
    chk("after_wrap_wrap", int'(wrap), 0);

    // Pause at prescaler phase 2; 3 more enabled edges complete the period.
    cyc(1);
    enable = 1'b0;
    cyc(7);
    chk("paused_ms", int'(ms_tick), 0);
    enable = 1'b1;
    cyc(2);
    chk("resume_ms_early", int'(ms_tick), 0);
    cyc(1);
    chk("resume_ms", int'(ms_tick), 1);
    chk("resume_cnt", int'(counter), 1);

    // Load 12 on a tick edge saturates to 9 with no step and no wrap.
    cyc(4);
    load     = 1'b1;
    load_val = 4'd12;
    cyc(1);
    load = 1'b0;
    chk("load_tick_cnt",  int'(counter), 9);
    chk("load_tick_ms",   int'(ms_tick), 1);
    chk("load_tick_wrap", int'(wrap),    0);
    chk("load_tick_flip", int'(flip),    1);

    // Off-tick load keeps the prescaler phase.
    cyc(2);
    load     = 1'b1;
    load_val = 4'd3;
    cyc(1);
    load = 1'b0;
    chk("load_off_cnt", int'(counter), 3);
    cyc(1);
    chk("load_off_ms_early", int'(ms_tick), 0);
    cyc(1);
    chk("load_off_ms", int'(ms_tick), 1);
    chk("load_off_next_cnt", int'(counter), 4);

`ifdef PRESCALED_COUNTER_UPDOWN_EN
    // Down from 0 wraps to 9, then steps to 8.
    load     = 1'b1;
    load_val = 4'd0;
    up_dn    = 1'b0;
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("down_wrap_cnt",  int'(counter), 9);
    chk("down_wrap_wrap", int'(wrap),    1);
    cyc(5);
    chk("down_step_cnt", int'(counter), 8);
    up_dn = 1'b1;
`endif

    // Clear + load + reset on a tick edge, then clear + load alone on a tick edge.
    cyc(4);
    reset = 1'b1;
    clear = 1'b1;
    load  = 1'b1;
    cyc(1);
    chk("rst_clr_cnt", int'(counter), 0);
    chk("rst_clr_ms",  int'(ms_tick), 0);
    reset = 1'b0;
    load  = 1'b1;
    cyc(1);
    clear = 1'b0;
    load  = 1'b0;
    cyc(4);
    clear = 1'b1;
    load  = 1'b1;
    cyc(1);
    clear = 1'b0;
    load  = 1'b0;
    chk("clr_tick_ms",  int'(ms_tick), 0);
    chk("clr_tick_cnt", int'(counter), 0);

    // Reset mid-period discards the partial count.
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    chk("mid_rst_ms_early", int'(ms_tick), 0);
    cyc(1);
    chk("mid_rst_ms", int'(ms_tick), 1);
    chk("mid_rst_cnt", int'(counter), 1);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      enable   = ($urandom_range(0, 3) != 0);
`ifdef PRESCALED_COUNTER_UPDOWN_EN
      if ($urandom_range(0, 31) == 0) up_dn = ~up_dn;
`endif
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
